// File: rtl/pe_alu_pkg.sv
// Shared opcode definitions for the PE ALU pipeline.
// Optional build macro: PE_ALU_SATURATE_EN (signed saturation for ADD/SUB/ACC).
package pe_alu_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SEL = 5;
    localparam int OP_MAC = 6;
    localparam int OP_ACC = 7;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SEL = 3'd5,
        ALU_MAC = 3'd6,
        ALU_ACC = 3'd7
    } alu_op_e;

endpackage

// File: rtl/pe_alu_core.sv
// Combinational PE operation selected by the static ALU_FUNC.
// Optional build macro: PE_ALU_SATURATE_EN.
module pe_alu_core
    import pe_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_FUNC   = 0
) (
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] result
);

`ifdef PE_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam bit      OP_OK = (ALU_FUNC >= 0) && (ALU_FUNC <= 7);
    localparam alu_op_e OP    = alu_op_e'(ALU_FUNC[2:0]);

    localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [DATA_WIDTH-1:0] prod;

    assign sum     = in1 + in2;
    assign diff    = in1 - in2;
    assign acc_sum = acc + in1;
    assign prod    = in1 * in2;

    // Overflow iff both addend signs agree and the result sign differs.
    // Subtraction is handled by passing the inverted subtrahend sign.
    function automatic logic [DATA_WIDTH-1:0] sat_fix(
        input logic                  sa,
        input logic                  sb,
        input logic [DATA_WIDTH-1:0] r
    );
        if (SAT && (sa == sb) && (r[DATA_WIDTH-1] != sa))
            return sa ? MIN_V : MAX_V;
        return r;
    endfunction

    always_comb begin
        result = '0;
        if (OP_OK) begin
            unique case (OP)
                ALU_ADD: result = sat_fix(in1[DATA_WIDTH-1], in2[DATA_WIDTH-1], sum);
                ALU_SUB: result = sat_fix(in1[DATA_WIDTH-1], ~in2[DATA_WIDTH-1], diff);
                ALU_AND: result = in1 & in2;
                ALU_OR:  result = in1 | in2;
                ALU_XOR: result = in1 ^ in2;
                ALU_SEL: result = in3[0] ? in1 : in2;
                ALU_MAC: result = prod + in3;
                ALU_ACC: result = sat_fix(acc[DATA_WIDTH-1], in1[DATA_WIDTH-1], acc_sum);
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/pe_alu_pipe.sv
// Two-stage valid/ready PE pipeline with optional running accumulator.
// Optional build macro: PE_ALU_SATURATE_EN (passed through to pe_alu_core).
module pe_alu_pipe
    import pe_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_FUNC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam bit IS_ACC = (ALU_FUNC == OP_ACC);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH-1:0] result;
    logic                  adv2;
    logic                  adv1;
    logic                  accept;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    // A clear coinciding with an accepted operand starts from zero.
    assign acc_base = (IS_ACC && acc_clr) ? '0 : acc;

    pe_alu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ALU_FUNC   (ALU_FUNC)
    ) u_core (
        .in1    (data_in1),
        .in2    (data_in2),
        .in3    (data_in3),
        .acc    (acc_base),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_data <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid)
                data_out <= s1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (IS_ACC) begin
            if (accept)
                acc <= result;
            else if (acc_clr)
                acc <= '0;
        end
    end

endmodule
